// File: rtl/fork_sched_pkg.sv
// Shared constants and types for the fork scheduler.
package fork_sched_pkg;

    // Fork context: {start, ptr[15:0], pc[15:0]}
    localparam int CXT_W     = 33;
    localparam int START_BIT = 32;
    localparam int PTR_LSB   = 16;
    localparam int PC_LSB    = 0;
    localparam int PTR_W     = 16;
    localparam int PC_W      = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LAUNCH = 1'b1
    } state_t;

endpackage

// File: rtl/fork_sched_rr_pick.sv
// Round-robin first-one finder: returns the first set bit of req at or
// after index start, wrapping modulo N. start = 0 gives fixed priority.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan N positions starting at start; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(start) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fork_sched.sv
// Central fork scheduler: round-robin among busy requesters, launches the
// child on the lowest-index idle core with a one-cycle context pulse.
module fork_sched #(
    parameter int NCORES = 4,
    parameter int CXT_W  = fork_sched_pkg::CXT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCORES-1:0]       fork_req,
    input  logic [NCORES*16-1:0]    fork_ptr,
    input  logic [NCORES*16-1:0]    fork_pc,
    input  logic [NCORES-1:0]       halt,
    output logic [NCORES-1:0]       fork_ack,
    output logic [NCORES*CXT_W-1:0] fork_cxt,
    output logic [NCORES-1:0]       core_busy,
    output logic                    all_idle
);
    import fork_sched_pkg::*;

    localparam int IW = $clog2(NCORES);

    state_t                    state, state_d;
    logic [IW-1:0]             rr, rr_d;
    logic [IW-1:0]             r_q, t_q;
    logic                      lat_en;
    logic [NCORES-1:0]         ack_d, busy_d;
    logic [NCORES*CXT_W-1:0]   cxt_d;
    logic                      idle_d;

    logic                      r_found, t_found;
    logic [IW-1:0]             r_idx, t_idx;

    // Only running cores may fork; idle cores are valid targets.
    rr_pick #(.N(NCORES), .IW(IW)) u_req_pick (
        .req   (fork_req & core_busy),
        .start (rr),
        .found (r_found),
        .idx   (r_idx)
    );

    rr_pick #(.N(NCORES), .IW(IW)) u_free_pick (
        .req   (~core_busy),
        .start ('0),
        .found (t_found),
        .idx   (t_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ARB;
        else        state <= state_d;
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d = state;
        rr_d    = rr;
        lat_en  = 1'b0;
        ack_d   = '0;
        cxt_d   = '0;
        busy_d  = core_busy & ~halt;
        idle_d  = (core_busy == '0) && (state == ARB);
        case (state)
            ARB: begin
                if (r_found && t_found) begin
                    state_d = LAUNCH;
                    lat_en  = 1'b1;
                    ack_d[r_idx] = 1'b1;
                    cxt_d[int'(t_idx)*CXT_W + START_BIT] = 1'b1;
                    cxt_d[int'(t_idx)*CXT_W + PTR_LSB +: PTR_W] = fork_ptr[int'(r_idx)*16 +: 16];
                    cxt_d[int'(t_idx)*CXT_W + PC_LSB  +: PC_W]  = fork_pc[int'(r_idx)*16 +: 16];
                end
            end
            LAUNCH: begin
                // Target becomes busy as the start pulse ends; a halt of
                // the target cannot coincide since it was idle.
                busy_d[t_q] = 1'b1;
                rr_d        = (r_q == IW'(NCORES-1)) ? '0 : r_q + 1'b1;
                state_d     = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // Datapath and registered outputs; reset drops any pending launch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr        <= '0;
            r_q       <= '0;
            t_q       <= '0;
            fork_ack  <= '0;
            fork_cxt  <= '0;
            core_busy <= NCORES'(1);
            all_idle  <= 1'b0;
        end else begin
            rr        <= rr_d;
            fork_ack  <= ack_d;
            fork_cxt  <= cxt_d;
            core_busy <= busy_d;
            all_idle  <= idle_d;
            if (lat_en) begin
                r_q <= r_idx;
                t_q <= t_idx;
            end
        end
    end

endmodule

// File: tb/tb_fork_sched.sv
// Self-checking bench for fork_sched: directed steps then random traffic,
// every cycle compared against a cycle-level reference model.
module tb_fork_sched;

    localparam int NC = 4;
    localparam int CW = 33;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NC-1:0]      fork_req, halt;
    logic [NC*16-1:0]   fork_ptr, fork_pc;
    logic [NC-1:0]      fork_ack, core_busy;
    logic [NC*CW-1:0]   fork_cxt;
    logic               all_idle;

    fork_sched #(.NCORES(NC), .CXT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fork_req  (fork_req),
        .fork_ptr  (fork_ptr),
        .fork_pc   (fork_pc),
        .halt      (halt),
        .fork_ack  (fork_ack),
        .fork_cxt  (fork_cxt),
        .core_busy (core_busy),
        .all_idle  (all_idle)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit   [NC-1:0]    m_busy;
    bit               m_launch;
    int               m_r, m_t, m_rr;
    logic [NC-1:0]    m_ack;
    logic [NC*CW-1:0] m_cxt;
    logic             m_idle;
    logic [NC-1:0]    last_ack;

    int n_vec = 0;
    int n_err = 0;

    // Advance the model by one clock using the inputs sampled at the edge.
    task automatic model_edge();
        bit [NC-1:0] nb;
        int r, t, idx;
        logic [15:0] p, c;
        if (!rst_n) begin
            m_busy = 1; m_launch = 0; m_rr = 0;
            m_ack = '0; m_cxt = '0; m_idle = 1'b0;
            return;
        end
        m_idle = (m_busy == 0) && !m_launch;
        nb     = m_busy & ~halt;
        m_ack  = '0;
        m_cxt  = '0;
        if (m_launch) begin
            nb[m_t]  = 1'b1;
            m_rr     = (m_r + 1) % NC;
            m_launch = 0;
        end else begin
            r = -1;
            t = -1;
            for (int k = 0; k < NC; k++) begin
                idx = (m_rr + k) % NC;
                if (r < 0 && fork_req[idx] && m_busy[idx]) r = idx;
            end
            for (int i = 0; i < NC; i++)
                if (t < 0 && !m_busy[i]) t = i;
            if (r >= 0 && t >= 0) begin
                m_launch = 1;
                m_r = r;
                m_t = t;
                m_ack[r] = 1'b1;
                p = fork_ptr[r*16 +: 16];
                c = fork_pc[r*16 +: 16];
                m_cxt[t*CW +: CW] = {1'b1, p, c};
            end
        end
        m_busy = nb;
    endtask

    task automatic chk(input string tag, input logic [NC*CW-1:0] got, input logic [NC*CW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: model update, compare all outputs, retire acked requests
    // after their launch cycle, end halt pulses.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("fork_ack",  fork_ack,  m_ack);
        chk("fork_cxt",  fork_cxt,  m_cxt);
        chk("core_busy", core_busy, m_busy);
        chk("all_idle",  all_idle,  m_idle);
        fork_req = fork_req & ~last_ack;
        last_ack = m_ack;
        halt     = '0;
    endtask

    initial begin
        rst_n = 1'b0; fork_req = '0; halt = '0;
        fork_ptr = '0; fork_pc = '0; last_ack = '0;
        m_busy = 0; m_launch = 0; m_rr = 0; m_r = 0; m_t = 0;
        m_ack = '0; m_cxt = '0; m_idle = 1'b0;

        // Reset, then quiet: only the boot core busy, not idle.
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("boot_busy", core_busy, NC'(4'b0001));

        // Boot core halts: all_idle rises two cycles later and sticks.
        halt = 4'b0001;
        cyc(); cyc(); cyc(); cyc();
        chk("idle_sticky", all_idle, 1'b1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();

        // Core 0 forks onto core 1.
        fork_req[0] = 1'b1;
        fork_ptr[15:0] = 16'h0090;
        fork_pc[15:0]  = 16'h0010;
        cyc();
        chk("first_cxt1", fork_cxt[CW +: CW], 33'h1_0090_0010);
        chk("first_ack",  fork_ack, NC'(4'b0001));
        cyc();
        chk("first_busy", core_busy, NC'(4'b0011));
        cyc();

        // Core 0 forks again onto core 2.
        fork_req[0] = 1'b1;
        fork_ptr[15:0] = 16'h1234; fork_pc[15:0] = 16'h5678;
        repeat (3) cyc();

        // Three busy requesters, one free core; others stall until halt[3].
        fork_req = 4'b0111;
        fork_ptr = 64'hCCCC_2222_1111_0000;
        fork_pc  = 64'hDDDD_2BBB_1AAA_0999;
        repeat (6) cyc();
        halt = 4'b1000;
        repeat (5) cyc();
        halt = 4'b0100;
        repeat (5) cyc();

        // Request from an idle core is ignored.
        fork_req = '0;
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        fork_req[2] = 1'b1;
        repeat (4) cyc();
        chk("idle_req_ack", fork_ack, '0);
        fork_req = '0;

        // Reset during the launch cycle drops the launch.
        fork_req[0] = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("rst_cxt",  fork_cxt,  '0);
        chk("rst_busy", core_busy, NC'(4'b0001));
        rst_n = 1'b1; fork_req = '0;
        cyc();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NC; i++) begin
                if (!fork_req[i] && $urandom_range(3) == 0) fork_req[i] = 1'b1;
                if (m_busy[i] && $urandom_range(7) == 0) halt[i] = 1'b1;
            end
            fork_ptr = {$urandom(), $urandom()};
            fork_pc  = {$urandom(), $urandom()};
            rst_n = !(m_idle || $urandom_range(99) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
